// File: rtl/mem_if_pkg.sv
// Shared constants and state encoding for the CPU memory interface responders.
package mem_if_pkg;

  localparam int unsigned ADDR_W  = 6;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned RD_LAT  = 2;
  localparam int unsigned WR_HOLD = 2;
  localparam int unsigned DEPTH   = 2 ** ADDR_W;
  localparam int unsigned HOLD_W  = $clog2(WR_HOLD + 1);

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StSweep = 1'b1
  } state_e;

  // Saturating increment used by the write-hold counter.
  function automatic logic [HOLD_W-1:0] sat_inc(input logic [HOLD_W-1:0] cnt,
                                                input logic [HOLD_W-1:0] max);
    return (cnt == max) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/wr_hold_detect.sv
// Write-request qualifier: counts cycles of a stable, held write request and
// emits a single commit pulse when the hold requirement is first met.
module wr_hold_detect
  import mem_if_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              block,
  input  logic              mode,
  input  logic [ADDR_W-1:0] adrs,
  input  logic [ADDR_W-1:0] adrs_q,
  input  logic [DATA_W-1:0] data,
  output logic              commit
);

  localparam logic [HOLD_W-1:0] HoldMax = HOLD_W'(WR_HOLD);
  localparam logic [HOLD_W-1:0] HoldOne = HOLD_W'(1);

  logic [DATA_W-1:0] data_q;
  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_d;
  logic              stable;

  always_comb begin
    stable = mode && (adrs == adrs_q) && (data == data_q);
    hold_d = '0;
    if (block) begin
      hold_d = '0;
    end else if (stable) begin
      hold_d = sat_inc(hold_q, HoldMax);
    end else begin
      hold_d = mode ? HoldOne : '0;
    end
    // Fire only on the transition into the saturated count, never while parked there.
    commit = !block && mode && (hold_d == HoldMax) && !(stable && (hold_q == HoldMax));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      hold_q <= '0;
    end else begin
      data_q <= data;
      hold_q <= hold_d;
    end
  end

endmodule

// File: rtl/sync_mem_responder.sv
// Responder end of the CPU memory interface: fixed-latency read pipe, held-write
// commit and a full-array clear sweep started by reset or an erase edge.
module sync_mem_responder
  import mem_if_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] adrs,
  input  logic              mode,
  input  logic              erase,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] out,
  output logic              busy
);

  state_e            state;
  logic [ADDR_W:0]   ptr;
  logic [ADDR_W:0]   ptr_nxt;
  logic              erase_q;
  logic              erase_edge;
  logic              block;
  logic              commit;
  logic [ADDR_W-1:0] adrs_q;
  logic [DATA_W-1:0] mem [DEPTH];

  assign erase_edge = erase & ~erase_q;
  // An erase edge in idle preempts any write that would commit on the same edge.
  assign block      = (state == StSweep) | erase_edge;
  assign ptr_nxt    = ptr + 1'b1;

  wr_hold_detect u_wr_hold_detect (
    .clk    (clk),
    .rst    (rst),
    .block  (block),
    .mode   (mode),
    .adrs   (adrs),
    .adrs_q (adrs_q),
    .data   (data),
    .commit (commit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= StSweep;
      ptr     <= '0;
      busy    <= 1'b1;
      out     <= '0;
      erase_q <= 1'b0;
      adrs_q  <= '0;
    end else begin
      erase_q <= erase;
      adrs_q  <= adrs;
      unique case (state)
        StIdle: begin
          if (erase_edge) begin
            state <= StSweep;
            ptr   <= '0;
            busy  <= 1'b1;
            out   <= '0;
          end else begin
            out <= mem[adrs_q];
          end
        end
        StSweep: begin
          out <= '0;
          if (erase_edge) begin
            ptr <= '0;
          end else if (ptr_nxt[ADDR_W]) begin
            // Extra pointer bit marks that the last word has just been cleared.
            state <= StIdle;
            busy  <= 1'b0;
            ptr   <= '0;
          end else begin
            ptr <= ptr_nxt;
          end
        end
        default: begin
          state <= StSweep;
          ptr   <= '0;
          busy  <= 1'b1;
          out   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == StSweep) begin
      mem[ptr[ADDR_W-1:0]] <= '0;
    end else if (commit) begin
      mem[adrs] <= data;
    end
  end

  busy_tracks_state: assert property (@(posedge clk) disable iff (rst)
    busy == (state == StSweep));

  no_commit_in_sweep: assert property (@(posedge clk) disable iff (rst)
    !(commit && (state == StSweep)));

endmodule

// File: tb/tb_sync_mem_responder.sv
// Bench for sync_mem_responder: directed scenarios plus randomized traffic, all
// checked every cycle against a transaction-level model of the memory.
module tb_sync_mem_responder;
  import mem_if_pkg::*;

  logic              clk   = 1'b0;
  logic              rst   = 1'b1;
  logic              mode  = 1'b0;
  logic              erase = 1'b0;
  logic [ADDR_W-1:0] adrs  = '0;
  logic [DATA_W-1:0] data  = '0;
  logic [DATA_W-1:0] out;
  logic              busy;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  sync_mem_responder dut (
    .clk   (clk),
    .rst   (rst),
    .adrs  (adrs),
    .mode  (mode),
    .erase (erase),
    .data  (data),
    .out   (out),
    .busy  (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // Model: a sweep is observed as "memory becomes zero, busy for DEPTH cycles,
  // out reads zero"; a write lands when the same request has been seen WR_HOLD times.
  logic [DATA_W-1:0] m_mem [DEPTH];
  int                m_left;
  int                m_run;
  logic [ADDR_W-1:0] m_pa;
  logic [DATA_W-1:0] m_pd;
  logic              m_pe;
  logic [DATA_W-1:0] exp_out;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = '0;
      m_left  = int'(DEPTH);
      m_run   = 0;
      m_pa    = '0;
      m_pd    = '0;
      m_pe    = 1'b0;
      exp_out = '0;
    end else begin
      if (m_left > 0) begin
        exp_out = '0;
        m_run   = 0;
        m_left  = (erase && !m_pe) ? int'(DEPTH) : m_left - 1;
      end else if (erase && !m_pe) begin
        for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = '0;
        m_left  = int'(DEPTH);
        exp_out = '0;
        m_run   = 0;
      end else begin
        exp_out = m_mem[m_pa];
        if (mode && adrs == m_pa && data == m_pd) m_run++;
        else m_run = mode ? 1 : 0;
        if (m_run == int'(WR_HOLD)) m_mem[adrs] = data;
      end
      m_pa = adrs;
      m_pd = data;
      m_pe = erase;
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("busy_vs_model", 32'(busy), 32'(m_left != 0));
      check("out_vs_model", 32'(out), 32'(exp_out));
    end
  end

  // All stimulus tasks start and end just after a falling edge.
  task automatic drive(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       input logic m, input int n);
    adrs = a;
    data = d;
    mode = m;
    repeat (n) @(negedge clk);
  endtask

  task automatic read(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] v);
    adrs = a;
    mode = 1'b0;
    repeat (RD_LAT) @(negedge clk);
    v = out;
  endtask

  task automatic wait_busy(output int cnt);
    cnt = 0;
    while (busy && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int                cnt;
    int                len;
    logic [DATA_W-1:0] v;

    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd1);
    check("reset_out", 32'(out), 32'd0);

    // T1: reset sweep length and cleared array
    rst    = 1'b0;
    chk_en = 1'b1;
    wait_busy(cnt);
    check("t1_busy_len", 32'(cnt), 32'(DEPTH));
    for (int a = 0; a < int'(DEPTH); a++) begin
      read(ADDR_W'(a), v);
      check("t1_read_zero", 32'(v), 32'h00);
    end

    // T2: held write commits
    drive(6'd5, 8'hA5, 1'b1, 3);
    read(6'd5, v);
    check("t2_read5", 32'(v), 32'hA5);

    // T3: single-cycle write must not commit
    drive(6'd5, 8'h3C, 1'b1, 1);
    read(6'd5, v);
    check("t3_read5", 32'(v), 32'hA5);

    // T4: address change restarts the hold
    drive(6'd7, 8'h11, 1'b1, 1);
    drive(6'd8, 8'h11, 1'b1, 3);
    read(6'd8, v);
    check("t4_read8", 32'(v), 32'h11);
    read(6'd7, v);
    check("t4_read7", 32'(v), 32'h00);

    // T5: erase, with a write attempted throughout the sweep
    erase = 1'b1;
    @(negedge clk);
    erase = 1'b0;
    adrs  = 6'd9;
    data  = 8'h77;
    mode  = 1'b1;
    cnt   = 1;
    while (busy && cnt < 200) begin
      if (out !== '0) check("t5_out_in_sweep", 32'(out), 32'h00);
      cnt++;
      @(negedge clk);
    end
    mode = 1'b0;
    check("t5_busy_len", 32'(cnt), 32'(DEPTH + 1));
    for (int a = 0; a < int'(DEPTH); a++) begin
      read(ADDR_W'(a), v);
      check("t5_read_zero", 32'(v), 32'h00);
    end

    // T6a: async reset while out holds nonzero data
    drive(6'd3, 8'h5A, 1'b1, 3);
    read(6'd3, v);
    check("t6_read3", 32'(v), 32'h5A);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6a_async_out", 32'(out), 32'h00);
    check("t6a_async_busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    wait_busy(cnt);
    check("t6a_busy_len", 32'(cnt), 32'(DEPTH));

    // T6b: async reset in the middle of an erase sweep
    drive(6'd3, 8'h5A, 1'b1, 3);
    erase = 1'b1;
    @(negedge clk);
    erase = 1'b0;
    mode  = 1'b0;
    repeat (30) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6b_async_out", 32'(out), 32'h00);
    check("t6b_async_busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    wait_busy(cnt);
    check("t6b_busy_len", 32'(cnt), 32'(DEPTH));
    read(6'd3, v);
    check("t6b_read3", 32'(v), 32'h00);

    // Randomized traffic on a narrow address range so holds and reads collide.
    repeat (600) begin
      len   = int'($urandom_range(1, 4));
      adrs  = ADDR_W'($urandom_range(0, 7));
      data  = DATA_W'($urandom_range(1, 255));
      mode  = ($urandom_range(0, 2) != 0);
      erase = ($urandom_range(0, 59) == 0);
      @(negedge clk);
      erase = 1'b0;
      repeat (len - 1) @(negedge clk);
    end
    mode = 1'b0;
    repeat (DEPTH + 4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
